// File: rtl/spi_frame_sched.sv
// Frame controller: counts SPI bytes, buffers payload, validates checksum and commits config atomically.
// Latency: frame_end in cycle n -> commit/frame_err and new config in cycle n+2; no backpressure, every byte pulse is consumed.
module spi_frame_sched #(
    parameter int F         = 11,
    parameter int T         = 4,
    parameter int MAX_BYTES = 20
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         frame_start_i,
    input  logic         frame_end_i,
    input  logic         byte_valid_i,
    input  logic [7:0]   byte_data_i,
    output logic [4:0]   byte_idx_o,
    output logic [F:0]   vel0_o,
    output logic [F:0]   vel1_o,
    output logic [F:0]   vel2_o,
    output logic [F:0]   vel3_o,
    output logic [13:0]  dout_o,
    output logic [T-1:0] dirtime_o,
    output logic [T-1:0] steptime_o,
    output logic [1:0]   tap_o,
    output logic         spolarity_o,
    output logic         commit_o,
    output logic         wdt_kick_o,
    output logic         frame_err_o,
    output logic [7:0]   err_cnt_o
);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    localparam logic [4:0] MAX_IDX = 5'(MAX_BYTES);

    state_t         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [7:0]     sum_q, sum_d;
    logic [7:0]     shadow_q [12];
    logic [F:0]     vel0_q, vel1_q, vel2_q, vel3_q;
    logic [13:0]    dout_q;
    logic [T-1:0]   dirtime_q, steptime_q;
    logic [1:0]     tap_q;
    logic           spol_q;
    logic           commit_q, commit_d;
    logic           wdt_q, wdt_d;
    logic           ferr_q, ferr_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic           shadow_we;
    logic           load_cfg;
    logic           frame_ok;
    logic [15:0]    w01, w23, w45, w67;

    assign w01 = {shadow_q[1], shadow_q[0]};
    assign w23 = {shadow_q[3], shadow_q[2]};
    assign w45 = {shadow_q[5], shadow_q[4]};
    assign w67 = {shadow_q[7], shadow_q[6]};

    // idx saturates at 31, so an over-long frame can never wrap back into the legal window
    assign frame_ok = (idx_q >= 5'd13) && (idx_q <= MAX_IDX) && (sum_q == 8'd0);

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start_i) state_d = RECV;
            RECV:    if (frame_start_i) state_d = RECV;
                     else if (frame_end_i) state_d = CHECK;
            CHECK:   state_d = frame_start_i ? RECV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d     = idx_q;
        sum_d     = sum_q;
        shadow_we = 1'b0;
        load_cfg  = 1'b0;
        commit_d  = 1'b0;
        wdt_d     = 1'b0;
        ferr_d    = 1'b0;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    idx_d = 5'd0;
                    sum_d = 8'd0;
                end
            end
            RECV: begin
                if (frame_start_i) begin
                    ferr_d = 1'b1;
                    idx_d  = 5'd0;
                    sum_d  = 8'd0;
                end else if (byte_valid_i) begin
                    shadow_we = (idx_q <= 5'd11);
                    if (idx_q <= 5'd12) sum_d = sum_q + byte_data_i;
                    if (idx_q != 5'd31) idx_d = idx_q + 5'd1;
                end
            end
            CHECK: begin
                if (frame_ok) begin
                    load_cfg = 1'b1;
                    commit_d = 1'b1;
                    wdt_d    = shadow_q[9][6];
                end else begin
                    ferr_d = 1'b1;
                end
                if (frame_start_i) begin
                    idx_d = 5'd0;
                    sum_d = 8'd0;
                end
            end
            default: ;
        endcase
        if (ferr_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q      <= '0;
            sum_q      <= '0;
            for (int i = 0; i < 12; i++) shadow_q[i] <= '0;
            vel0_q     <= '0;
            vel1_q     <= '0;
            vel2_q     <= '0;
            vel3_q     <= '0;
            dout_q     <= '0;
            dirtime_q  <= '0;
            steptime_q <= '0;
            tap_q      <= '0;
            spol_q     <= 1'b0;
            commit_q   <= 1'b0;
            wdt_q      <= 1'b0;
            ferr_q     <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            if (shadow_we) shadow_q[idx_q[3:0]] <= byte_data_i;
            commit_q  <= commit_d;
            wdt_q     <= wdt_d;
            ferr_q    <= ferr_d;
            err_cnt_q <= err_cnt_d;
            if (load_cfg) begin
                vel0_q     <= w01[F:0];
                vel1_q     <= w23[F:0];
                vel2_q     <= w45[F:0];
                vel3_q     <= w67[F:0];
                dout_q     <= {shadow_q[9][5:0], shadow_q[8]};
                spol_q     <= shadow_q[10][7];
                dirtime_q  <= shadow_q[10][T-1:0];
                tap_q      <= shadow_q[11][7:6];
                steptime_q <= shadow_q[11][T-1:0];
            end
        end
    end

    assign byte_idx_o  = idx_q;
    assign vel0_o      = vel0_q;
    assign vel1_o      = vel1_q;
    assign vel2_o      = vel2_q;
    assign vel3_o      = vel3_q;
    assign dout_o      = dout_q;
    assign dirtime_o   = dirtime_q;
    assign steptime_o  = steptime_q;
    assign tap_o       = tap_q;
    assign spolarity_o = spol_q;
    assign commit_o    = commit_q;
    assign wdt_kick_o  = wdt_q;
    assign frame_err_o = ferr_q;
    assign err_cnt_o   = err_cnt_q;

endmodule
